sync_fifo_flags: RTL
====================

Name: sync_fifo_flags

Overview:
- Next-generation synchronous FIFO built on read/write pointers.
- Adds these features over a plain counter FIFO:
  - arbitrary (non-power-of-2) depth
  - programmable almost-full/almost-empty thresholds
  - selectable standard or first-word-fall-through (FWFT) read mode
  - overflow/underflow error pulses
  - correct ordering on simultaneous read and write
- Used as a general single-clock buffer between producer/consumer stages in the datapath.

Parameters:
- DATA_WIDTH, 8, data bit width (>=1).
- DATA_DEPTH, 16, number of entries (>=2, any integer).
- AF_LEVEL, 14, almost_full asserts when fifo_cnt >= AF_LEVEL (1..DATA_DEPTH).
- AE_LEVEL, 2, almost_empty asserts when fifo_cnt <= AE_LEVEL (0..DATA_DEPTH-1).
- FWFT, 0, 0 = standard registered read; 1 = first-word-fall-through.

Ports:
- clk  input  1  system clock, all logic on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- data_in  input  DATA_WIDTH  write data.
- wr_en  input  1  write request, active high.
- rd_en  input  1  read request, active high.
- data_out  output  DATA_WIDTH  read data.
- full  output  1  fifo_cnt == DATA_DEPTH.
- empty  output  1  fifo_cnt == 0.
- almost_full  output  1  fifo_cnt >= AF_LEVEL.
- almost_empty  output  1  fifo_cnt <= AE_LEVEL.
- overflow  output  1  one-cycle pulse, write rejected.
- underflow  output  1  one-cycle pulse, read rejected.
- fifo_cnt  output  $clog2(DATA_DEPTH+1)  current occupancy.

Behaviour:
- Reset (async assert, sync release):
  - wr_ptr, rd_ptr, fifo_cnt, data_out, overflow and underflow all clear to 0.
  - empty=1, full=0, almost_empty=1.
  - almost_full = (AF_LEVEL==0 ? 1 : 0).
  - RAM contents are not reset.
  - Reset mid-operation discards all stored data; the first access after release behaves as on an empty FIFO.
- Accept rules:
  - wr_acc = wr_en & ~full.
  - rd_acc = rd_en & ~empty.
  - Decisions use flag values from before the edge.
- Pointers:
  - Range 0..DATA_DEPTH-1.
  - Increment on acceptance; wrap from DATA_DEPTH-1 to 0, with an explicit compare so non-power-of-2 depths work.
  - Write stores data_in at mem[wr_ptr].
- Count update per edge:
  - wr_acc only: +1.
  - rd_acc only: -1.
  - Both: unchanged.
  - fifo_cnt never exceeds DATA_DEPTH and never goes below 0.
- Simultaneous read and write:
  - When full: read accepted, write rejected (overflow=1), count goes DATA_DEPTH -> DATA_DEPTH-1.
  - When empty: write accepted, read rejected (underflow=1), count goes 0 -> 1. No bypass of data_in to data_out.
  - Otherwise both are accepted; data order is strictly preserved.
- Flags:
  - full, empty, almost_full and almost_empty are decoded from the registered fifo_cnt.
  - They update on the same edge as the count.
- Error pulses:
  - overflow is registered: 1 for exactly the cycle after an edge where wr_en & full.
  - underflow is registered: 1 for exactly the cycle after an edge where rd_en & empty.
  - State is unaffected by rejected requests.
- FWFT=0 (standard mode):
  - On rd_acc, data_out <= mem[rd_ptr], registered. Valid the cycle after the read edge.
  - data_out holds its value when no read is accepted.
  - Timing: a write at edge N clears empty after N; a read at edge N+1 presents the data after edge N+1.
- FWFT=1:
  - data_out = mem[rd_ptr], combinational from the array. Shows the head word whenever empty=0.
  - rd_acc pops the head; the next word appears after the edge.
  - Value while empty is don't-care; the bench checks data only while empty=0.

Test Plan:
- Default params, FWFT=0, write 0x01..0x10 back-to-back:
  - full=1 after the 16th edge; almost_full=1 from fifo_cnt=14.
  - A 17th write gives an overflow pulse; fifo_cnt stays 16.
- From full, read 16 times:
  - data_out = 0x01..0x10 in order, each one cycle after its read edge.
  - empty=1 and almost_empty=1 at fifo_cnt<=2.
  - An extra read gives an underflow pulse; data_out holds 0x10.
- DATA_DEPTH=12, interleave writes and reads across 40 words:
  - Pointers wrap at 11->0.
  - Output sequence matches input; fifo_cnt never exceeds 12.
- Simultaneous wr_en & rd_en:
  - At full: count 12 -> 11, overflow=1, head word read out.
  - At empty: count 0 -> 1, underflow=1.
  - At count 5: count stays 5 and order is preserved.
- FWFT=1, write 0xA5 to an empty FIFO:
  - data_out=0xA5 and empty=0 the cycle after the write, with no rd_en.
  - rd_en for one cycle pops it; empty=1 afterwards.
- Write 7 words, then assert rst_n=0 mid-stream for 1 cycle:
  - Immediately fifo_cnt=0, empty=1, data_out=0, overflow/underflow=0.
  - A subsequent write of 0x3C reads back as 0x3C.

Source files
------------

// File: rtl/sync_fifo_flags.sv
// Single-clock FIFO with read/write pointers, any depth >= 2, programmable
// almost-full/almost-empty levels, standard or first-word-fall-through read
// mode, and registered overflow/underflow pulses.
//
// Handshake: a write is taken on a rising edge when wr_en=1 and full=0; a read
// is taken when rd_en=1 and empty=0. Both decisions use the flags as they were
// before the edge. A request made against full/empty is dropped, leaves all
// state untouched and raises overflow/underflow for the following cycle.
module sync_fifo_flags #(
    parameter int DATA_WIDTH = 8,
    parameter int DATA_DEPTH = 16,
    parameter int AF_LEVEL   = 14,
    parameter int AE_LEVEL   = 2,
    parameter int FWFT       = 0,
    localparam int CW        = $clog2(DATA_DEPTH + 1)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  wr_en,
    input  logic                  rd_en,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  full,
    output logic                  empty,
    output logic                  almost_full,
    output logic                  almost_empty,
    output logic                  overflow,
    output logic                  underflow,
    output logic [CW-1:0]         fifo_cnt
);

    localparam int            PW       = $clog2(DATA_DEPTH);
    localparam logic [PW-1:0] PTR_LAST = PW'(DATA_DEPTH - 1);
    localparam logic [CW-1:0] DEPTH_C  = CW'(DATA_DEPTH);
    localparam logic [CW-1:0] AF_C     = CW'(AF_LEVEL);
    localparam logic [CW-1:0] AE_C     = CW'(AE_LEVEL);

    logic [DATA_WIDTH-1:0] mem_q [DATA_DEPTH];
    logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0] dout_q;
    logic                  ovf_q, udf_q;
    logic                  full_s, empty_s;
    logic                  wr_acc, rd_acc;

    // Flags are a pure decode of the registered count, so they move with it.
    assign full_s       = (cnt_q == DEPTH_C);
    assign empty_s      = (cnt_q == '0);
    assign full         = full_s;
    assign empty        = empty_s;
    assign almost_full  = (cnt_q >= AF_C);
    assign almost_empty = (cnt_q <= AE_C);
    assign fifo_cnt     = cnt_q;
    assign overflow     = ovf_q;
    assign underflow    = udf_q;

    // At full a simultaneous read is still taken (write dropped); at empty the
    // write is taken (read dropped), and data_in is never bypassed to data_out.
    assign wr_acc = wr_en & ~full_s;
    assign rd_acc = rd_en & ~empty_s;

    // FWFT shows the head word straight from the array; standard mode uses the
    // register loaded on each accepted read.
    assign data_out = (FWFT != 0) ? mem_q[rd_ptr_q] : dout_q;

    // Next pointers wrap by explicit compare so non-power-of-2 depths work.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (wr_acc) begin
            wr_ptr_d = (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + PW'(1);
        end
        if (rd_acc) begin
            rd_ptr_d = (rd_ptr_q == PTR_LAST) ? '0 : rd_ptr_q + PW'(1);
        end
        case ({wr_acc, rd_acc})
            2'b10:   cnt_d = cnt_q + CW'(1);
            2'b01:   cnt_d = cnt_q - CW'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    // Control state, read register and error pulses; all cleared by reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            dout_q   <= '0;
            ovf_q    <= 1'b0;
            udf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
            ovf_q    <= wr_en & full_s;
            udf_q    <= rd_en & empty_s;
            if (rd_acc) begin
                dout_q <= mem_q[rd_ptr_q];
            end
        end
    end

    // Storage array; contents deliberately survive reset.
    always_ff @(posedge clk) begin
        if (wr_acc) begin
            mem_q[wr_ptr_q] <= data_in;
        end
    end

endmodule
